// File: rtl/nand_target_pkg.sv
// Shared definitions for the NAND flash target: command opcodes, FSM states,
// pending-operation codes and status byte layout.
package nand_target_pkg;

    localparam logic [7:0] CMD_READ       = 8'h00;
    localparam logic [7:0] CMD_READ_CONF  = 8'h30;
    localparam logic [7:0] CMD_PROG       = 8'h80;
    localparam logic [7:0] CMD_PROG_CONF  = 8'h10;
    localparam logic [7:0] CMD_ERASE      = 8'h60;
    localparam logic [7:0] CMD_ERASE_CONF = 8'hD0;
    localparam logic [7:0] CMD_STATUS     = 8'h70;
    localparam logic [7:0] CMD_ID         = 8'h90;
    localparam logic [7:0] CMD_RESET      = 8'hFF;

    typedef enum logic [2:0] {
        IDLE, ADDR, DATA_IN, WAIT_CONFIRM, BUSY, DATA_OUT, STATUS_OUT, ID_OUT
    } state_t;

    typedef enum logic [2:0] {
        OP_READ, OP_PROG, OP_ERASE, OP_ID, OP_RST
    } op_t;

    localparam int STAT_NOT_WP = 7;
    localparam int STAT_READY  = 6;
    localparam int STAT_FAIL   = 0;

endpackage

// File: rtl/nand_strobe_detect.sv
// Turns the raw wEn/rEn pins into single-cycle rising-edge pulses in the clk
// domain, qualified by chip enable.
module nand_strobe_detect (
    input  logic clk,
    input  logic rst,
    input  logic cen_i,
    input  logic wen_i,
    input  logic ren_i,
    output logic wr_stb_o,
    output logic rd_adv_o
);
    logic wen_q;
    logic ren_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen_q <= 1'b1;
            ren_q <= 1'b1;
        end else begin
            wen_q <= wen_i;
            ren_q <= ren_i;
        end
    end

    assign wr_stb_o = ~cen_i & ~wen_q & wen_i;
    assign rd_adv_o = ~cen_i & ~ren_q & ren_i;

endmodule

// File: rtl/nand_flash_target.sv
// Device-side NAND flash responder: decodes command/address/data cycles,
// holds a page-organised array plus one page register, and models busy time.
module nand_flash_target
    import nand_target_pkg::*;
#(
    parameter int         PageBytes     = 16,
    parameter int         Pages         = 16,
    parameter int         PagesPerBlock = 4,
    parameter int         tR            = 8,
    parameter int         tPROG         = 20,
    parameter int         tBERS         = 40,
    parameter int         tRST          = 4,
    parameter logic [7:0] ManufId       = 8'hEC,
    parameter logic [7:0] DevId         = 8'hDA
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       cEn,
    input  logic       CLE,
    input  logic       ALE,
    input  logic       wEn,
    input  logic       rEn,
    inout  wire  [7:0] DIO,
    output logic       RB
);
    localparam int CW = $clog2(PageBytes);
    localparam int RW = $clog2(Pages);

    state_t          state_q, state_d, prev_q, prev_d;
    op_t             op_q, op_d;
    logic [CW-1:0]   col_q, col_d;
    logic [7:0]      row_q, row_d;
    logic            fail_q, fail_d, busy_q, busy_d;
    logic            addr_idx_q, addr_idx_d, id_sel_q, id_sel_d;
    logic [15:0]     cnt_q, cnt_d;

    logic [PageBytes*8-1:0] mem_q [Pages];
    logic [7:0]             page_q [PageBytes];
    logic [PageBytes*8-1:0] page_vec;

    logic            wr_stb, rd_adv;
    logic            page_fill, page_wr, page_load, mem_prog, mem_erase;
    logic [7:0]      dio_in, dout;
    logic            oe, row_bad;
    logic [RW-1:0]   row_idx;
    state_t          eff_state, done_state;

    nand_strobe_detect u_strobe (
        .clk      (clk),
        .rst      (Reset),
        .cen_i    (cEn),
        .wen_i    (wEn),
        .ren_i    (rEn),
        .wr_stb_o (wr_stb),
        .rd_adv_o (rd_adv)
    );

    genvar gi;
    generate
        for (gi = 0; gi < PageBytes; gi++) begin : g_page_vec
            assign page_vec[gi*8 +: 8] = page_q[gi];
        end
    endgenerate

    assign dio_in  = DIO;
    assign row_idx = row_q[RW-1:0];
    assign row_bad = {1'b0, row_q} >= 9'(Pages);

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            prev_q     <= IDLE;
            op_q       <= OP_READ;
            col_q      <= '0;
            row_q      <= '0;
            fail_q     <= 1'b0;
            busy_q     <= 1'b0;
            addr_idx_q <= 1'b0;
            id_sel_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            op_q       <= op_d;
            col_q      <= col_d;
            row_q      <= row_d;
            fail_q     <= fail_d;
            busy_q     <= busy_d;
            addr_idx_q <= addr_idx_d;
            id_sel_q   <= id_sel_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        op_d       = op_q;
        col_d      = col_q;
        row_d      = row_q;
        fail_d     = fail_q;
        busy_d     = busy_q;
        addr_idx_d = addr_idx_q;
        id_sel_d   = id_sel_q;
        cnt_d      = cnt_q;
        page_fill  = 1'b0;
        page_wr    = 1'b0;
        page_load  = 1'b0;
        mem_prog   = 1'b0;
        mem_erase  = 1'b0;
        done_state = (op_q == OP_READ) ? DATA_OUT : IDLE;

        // The busy timer keeps running while status is being read out.
        if (busy_q) begin
            if (cnt_q == '0) begin
                busy_d    = 1'b0;
                page_load = (op_q == OP_READ);
                mem_prog  = (op_q == OP_PROG) && !fail_q;
                mem_erase = (op_q == OP_ERASE) && !fail_q;
                if (state_q == BUSY)
                    state_d = done_state;
                else if (state_q == STATUS_OUT && prev_q == BUSY)
                    prev_d = done_state;
            end else begin
                cnt_d = cnt_q - 16'd1;
            end
        end

        eff_state = (state_q == STATUS_OUT) ? prev_d : state_d;

        if (wr_stb && CLE && !ALE) begin
            if (dio_in == CMD_STATUS) begin
                if (state_q != STATUS_OUT)
                    prev_d = state_d;
                state_d = STATUS_OUT;
            end else if (dio_in == CMD_RESET) begin
                state_d   = BUSY;
                busy_d    = 1'b1;
                cnt_d     = 16'(tRST - 1);
                op_d      = OP_RST;
                fail_d    = 1'b0;
                page_load = 1'b0;
                mem_prog  = 1'b0;
                mem_erase = 1'b0;
            end else begin
                state_d = eff_state;
                case (eff_state)
                    BUSY: ;
                    DATA_IN: begin
                        state_d = IDLE;
                        if (dio_in == CMD_PROG_CONF) begin
                            state_d = BUSY;
                            busy_d  = 1'b1;
                            cnt_d   = 16'(tPROG - 1);
                            fail_d  = row_bad;
                        end
                    end
                    WAIT_CONFIRM: begin
                        state_d = IDLE;
                        if (op_q == OP_READ && dio_in == CMD_READ_CONF) begin
                            state_d = BUSY;
                            busy_d  = 1'b1;
                            cnt_d   = 16'(tR - 1);
                        end else if (op_q == OP_ERASE && dio_in == CMD_ERASE_CONF) begin
                            state_d = BUSY;
                            busy_d  = 1'b1;
                            cnt_d   = 16'(tBERS - 1);
                            fail_d  = row_bad;
                        end
                    end
                    default: begin
                        state_d    = ADDR;
                        addr_idx_d = 1'b0;
                        case (dio_in)
                            CMD_READ:  op_d = OP_READ;
                            CMD_PROG:  begin op_d = OP_PROG; page_fill = 1'b1; end
                            CMD_ERASE: op_d = OP_ERASE;
                            CMD_ID:    op_d = OP_ID;
                            default:   state_d = IDLE;
                        endcase
                    end
                endcase
            end
        end else if (wr_stb && ALE && !CLE) begin
            if (state_q == ADDR) begin
                case (op_q)
                    OP_READ, OP_PROG: begin
                        if (!addr_idx_q) begin
                            col_d      = dio_in[CW-1:0];
                            addr_idx_d = 1'b1;
                        end else begin
                            row_d   = dio_in;
                            state_d = (op_q == OP_READ) ? WAIT_CONFIRM : DATA_IN;
                        end
                    end
                    OP_ERASE: begin
                        row_d   = dio_in;
                        state_d = WAIT_CONFIRM;
                    end
                    default: begin
                        id_sel_d = 1'b0;
                        state_d  = ID_OUT;
                    end
                endcase
            end
        end else if (wr_stb && !ALE && !CLE) begin
            if (state_q == DATA_IN) begin
                page_wr = 1'b1;
                col_d   = col_q + 1'b1;
            end
        end

        if (rd_adv) begin
            if (state_q == DATA_OUT)
                col_d = col_q + 1'b1;
            else if (state_q == ID_OUT)
                id_sel_d = ~id_sel_q;
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < PageBytes; i++) page_q[i] <= 8'hFF;
        end else if (page_fill) begin
            for (int i = 0; i < PageBytes; i++) page_q[i] <= 8'hFF;
        end else if (page_load) begin
            for (int i = 0; i < PageBytes; i++) page_q[i] <= mem_q[row_idx][i*8 +: 8];
        end else if (page_wr) begin
            page_q[col_q] <= dio_in;
        end
    end

    // Programming can only clear bits, so the page is ANDed into the array.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            for (int p = 0; p < Pages; p++) mem_q[p] <= '1;
        end else if (mem_prog) begin
            mem_q[row_idx] <= mem_q[row_idx] & page_vec;
        end else if (mem_erase) begin
            for (int p = 0; p < Pages; p++)
                if ((p / PagesPerBlock) == (int'(row_idx) / PagesPerBlock))
                    mem_q[p] <= '1;
        end
    end

    always_comb begin
        dout = page_q[col_q];
        if (state_q == STATUS_OUT) begin
            dout              = 8'h00;
            dout[STAT_NOT_WP] = 1'b1;
            dout[STAT_READY]  = ~busy_q;
            dout[STAT_FAIL]   = fail_q;
        end else if (state_q == ID_OUT) begin
            dout = id_sel_q ? DevId : ManufId;
        end
    end

    assign oe  = ~cEn & ~rEn &
                 (state_q == DATA_OUT || state_q == STATUS_OUT || state_q == ID_OUT);
    assign DIO = oe ? dout : 8'bz;
    assign RB  = ~busy_q;

endmodule

// File: tb/tb_nand_flash_target.sv
// Directed bench for nand_flash_target: a vector table of pin cycles with
// expected read bytes and busy lengths, plus hand sequences for aborts.
module tb_nand_flash_target;

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic       cEn = 1'b1, CLE = 1'b0, ALE = 1'b0, wEn = 1'b1, rEn = 1'b1;
    logic       tb_oe = 1'b0;
    logic [7:0] tb_dq = 8'h00;
    wire  [7:0] DIO;
    logic       RB;

    assign DIO = tb_oe ? tb_dq : 8'bz;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_pu
            pullup (DIO[gi]);
        end
    endgenerate

    nand_flash_target dut (
        .clk   (clk),
        .Reset (Reset),
        .cEn   (cEn),
        .CLE   (CLE),
        .ALE   (ALE),
        .wEn   (wEn),
        .rEn   (rEn),
        .DIO   (DIO),
        .RB    (RB)
    );

    always #5 clk = ~clk;

    typedef enum int { VC, VA, VD, VR, VW } vk_t;
    typedef struct {
        vk_t        kind;
        logic [7:0] val;
        int         exp;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic wr_cycle(input logic cle, input logic ale, input logic [7:0] b);
        @(negedge clk);
        cEn = 1'b0; CLE = cle; ALE = ale; tb_dq = b; tb_oe = 1'b1; wEn = 1'b0;
        @(negedge clk);
        wEn = 1'b1;
        @(negedge clk);
        CLE = 1'b0; ALE = 1'b0; tb_oe = 1'b0;
    endtask

    task automatic rd_byte(output logic [7:0] b);
        @(negedge clk);
        cEn = 1'b0; rEn = 1'b0;
        @(negedge clk);
        b = DIO;
        rEn = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_rb(output int n);
        n = 0;
        while (RB !== 1'b1 && n < 500) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic add(input vk_t k, input logic [7:0] v, input int e);
        vec_t x;
        x.kind = k; x.val = v; x.exp = e;
        vq.push_back(x);
    endtask

    task automatic add_prog1(input logic [7:0] row, input logic [7:0] col, input logic [7:0] d);
        add(VC, 8'h80, 0); add(VA, col, 0); add(VA, row, 0);
        add(VD, d, 0); add(VC, 8'h10, 0); add(VW, 0, 20);
    endtask

    task automatic add_read(input logic [7:0] row, input logic [7:0] col);
        add(VC, 8'h00, 0); add(VA, col, 0); add(VA, row, 0);
        add(VC, 8'h30, 0); add(VW, 0, 8);
    endtask

    // Hand-sequence helpers drive pins directly.
    task automatic do_cmd(input logic [7:0] b);  wr_cycle(1'b1, 1'b0, b); endtask
    task automatic do_addr(input logic [7:0] b); wr_cycle(1'b0, 1'b1, b); endtask
    task automatic do_data(input logic [7:0] b); wr_cycle(1'b0, 1'b0, b); endtask

    task automatic do_prog1(input logic [7:0] row, input logic [7:0] d);
        int n;
        do_cmd(8'h80); do_addr(8'h00); do_addr(row); do_data(d); do_cmd(8'h10);
        wait_rb(n);
        check($sformatf("prog row%0d busy", row), n, 20);
    endtask

    task automatic do_read1(input logic [7:0] row, input int exp);
        int n;
        logic [7:0] b;
        do_cmd(8'h00); do_addr(8'h00); do_addr(row); do_cmd(8'h30);
        wait_rb(n);
        check($sformatf("read row%0d busy", row), n, 8);
        rd_byte(b);
        check($sformatf("read row%0d col0", row), int'(b), exp);
    endtask

    initial begin
        logic [7:0] b;
        int         n;

        // Status, ID, program/read, AND-program, erase, wrap, bad row, bad confirm
        add(VC, 8'h70, 0); add(VR, 0, 8'hC0);
        add(VC, 8'h90, 0); add(VA, 8'h00, 0);
        add(VR, 0, 8'hEC); add(VR, 0, 8'hDA); add(VR, 0, 8'hEC);
        add(VC, 8'h80, 0); add(VA, 8'h02, 0); add(VA, 8'h05, 0);
        add(VD, 8'hA5, 0); add(VD, 8'h3C, 0); add(VC, 8'h10, 0); add(VW, 0, 20);
        add_read(8'h05, 8'h02); add(VR, 0, 8'hA5); add(VR, 0, 8'h3C); add(VR, 0, 8'hFF);
        add_prog1(8'h05, 8'h02, 8'h0F);
        add_read(8'h05, 8'h02); add(VR, 0, 8'h05);
        add_prog1(8'h04, 8'h00, 8'h12);
        add_prog1(8'h07, 8'h00, 8'h34);
        add_prog1(8'h08, 8'h00, 8'h56);
        add(VC, 8'h60, 0); add(VA, 8'h05, 0); add(VC, 8'hD0, 0); add(VW, 0, 40);
        add_read(8'h04, 8'h00); add(VR, 0, 8'hFF);
        add_read(8'h05, 8'h02); add(VR, 0, 8'hFF);
        add_read(8'h07, 8'h00); add(VR, 0, 8'hFF);
        add_read(8'h08, 8'h00); add(VR, 0, 8'h56);
        add(VC, 8'h80, 0); add(VA, 8'h0F, 0); add(VA, 8'h01, 0);
        add(VD, 8'h11, 0); add(VD, 8'h22, 0); add(VC, 8'h10, 0); add(VW, 0, 20);
        add_read(8'h01, 8'h0F); add(VR, 0, 8'h11); add(VR, 0, 8'h22); add(VR, 0, 8'hFF);
        add_prog1(8'h20, 8'h00, 8'h00);
        add(VC, 8'h70, 0); add(VR, 0, 8'hC1);
        add_read(8'h20, 8'h00); add(VR, 0, 8'hFF);
        add(VC, 8'h80, 0); add(VA, 8'h00, 0); add(VA, 8'h03, 0);
        add(VD, 8'h77, 0); add(VC, 8'h11, 0);
        add_read(8'h03, 8'h00); add(VR, 0, 8'hFF);

        // Reset state
        repeat (3) @(negedge clk);
        check("reset RB", int'(RB), 1);
        Reset = 1'b0;
        @(negedge clk);
        cEn = 1'b0; rEn = 1'b0;
        @(negedge clk);
        check("reset DIO hiZ", int'(DIO), 8'hFF);
        rEn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vq.size(); i++) begin
            case (vq[i].kind)
                VC: do_cmd(vq[i].val);
                VA: do_addr(vq[i].val);
                VD: do_data(vq[i].val);
                VR: begin
                    rd_byte(b);
                    check($sformatf("vec%0d read", i), int'(b), vq[i].exp);
                end
                default: begin
                    wait_rb(n);
                    check($sformatf("vec%0d busy", i), n, vq[i].exp);
                end
            endcase
        end

        // Status poll in the middle of an erase
        do_prog1(8'h09, 8'h42);
        do_cmd(8'h60); do_addr(8'h09); do_cmd(8'hD0);
        repeat (5) @(negedge clk);
        do_cmd(8'h70);
        rd_byte(b);
        check("status during erase", int'(b), 8'h80);
        wait_rb(n);
        check("erase ends", int'(RB), 1);
        rd_byte(b);
        check("status after erase", int'(b), 8'hC0);
        do_read1(8'h09, 8'hFF);

        // Reset command aborts an erase
        do_prog1(8'h0A, 8'h42);
        do_cmd(8'h60); do_addr(8'h0A); do_cmd(8'hD0);
        repeat (5) @(negedge clk);
        do_cmd(8'hFF);
        wait_rb(n);
        check("reset cmd busy", n, 4);
        do_read1(8'h0A, 8'h42);

        // Asynchronous reset in the middle of a program
        do_cmd(8'h80); do_addr(8'h00); do_addr(8'h0B); do_data(8'h99); do_cmd(8'h10);
        repeat (3) @(negedge clk);
        check("prog busy before reset", int'(RB), 0);
        #2 Reset = 1'b1;
        #1 check("async reset RB", int'(RB), 1);
        cEn = 1'b0; rEn = 1'b0;
        #1 check("async reset DIO hiZ", int'(DIO), 8'hFF);
        @(negedge clk);
        Reset = 1'b0; rEn = 1'b1;
        @(negedge clk);
        do_cmd(8'h70);
        rd_byte(b);
        check("status after async reset", int'(b), 8'hC0);
        do_read1(8'h0B, 8'hFF);
        do_read1(8'h08, 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nand_flash_target.md
Name: nand_flash_target

Overview:
- Synthesizable NAND flash device-side responder: the far end of the controller's CLE/ALE/wEn/rEn/cEn/DIO pin interface.
- Decodes command, address and data cycles and keeps a small page-organised register array with one page register.
- Models busy time on RB and serves status and ID reads.
- Serves as the emulation target the memory controller talks to in place of a real flash part.

Parameters:
- PageBytes, 16, bytes per page (power of 2).
- Pages, 16, pages in array (power of 2, at most 256).
- PagesPerBlock, 4, pages per erase block (power of 2).
- tR, 8, array-to-page-register busy cycles.
- tPROG, 20, program busy cycles.
- tBERS, 40, block erase busy cycles.
- tRST, 4, reset-command busy cycles.
- ManufId, 8'hEC, first ID byte.
- DevId, 8'hDA, second ID byte.

Ports:
- clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- cEn  in  1  chip enable, active low.
- CLE  in  1  command latch enable.
- ALE  in  1  address latch enable.
- wEn  in  1  write strobe, active low; latches on rising edge.
- rEn  in  1  read strobe, active low.
- DIO  inout  8  bidirectional data/command/address bus.
- RB  out  1  1 = ready, 0 = busy.

Behaviour:
- Strobes are sampled in the clk domain. Write strobe = wEn previous 0, now 1, with cEn=0. Read advance = rEn previous 0, now 1, with cEn=0.
- Cycle type on a write strobe:
  - CLE=1, ALE=0: command.
  - ALE=1, CLE=0: address.
  - Both 0: data.
  - Both 1: ignored.
- DIO is driven only when cEn=0, rEn=0 and state is DATA_OUT, STATUS_OUT or ID_OUT. Otherwise it is high-Z.
- Reset:
  - state IDLE, RB=1, DIO high-Z, col=0, row=0, fail=0, page register 0xFF.
  - All array bytes are set to 0xFF.
  - An asserted Reset mid-operation aborts the operation with no array update.
- States: IDLE, ADDR, DATA_IN, WAIT_CONFIRM, BUSY, DATA_OUT, STATUS_OUT, ID_OUT.
- Read (0x00):
  - ADDR takes 2 address cycles: column, then row. Then WAIT_CONFIRM.
  - 0x30 enters BUSY for tR cycles and copies array[row] into the page register.
  - Then DATA_OUT, with DIO = page_reg[col]. Each read advance does col++.
- Program (0x80):
  - The page register is filled with 0xFF, followed by 2 address cycles.
  - In DATA_IN, each data cycle writes page_reg[col] and increments col.
  - 0x10 enters BUSY for tPROG cycles, then array[row] = array[row] AND page_reg, then IDLE.
- Erase (0x60):
  - 1 address cycle (row), then 0xD0.
  - BUSY for tBERS cycles. Every page in the block containing row is set to 0xFF.
- Status (0x70):
  - Accepted in any state, including BUSY.
  - The previous state is saved and restored by the next non-0x70 command.
  - Status byte: bit7 = 1 (not write protected), bit6 = RB, bit0 = fail, others 0.
- ID (0x90):
  - 1 address cycle (any value), then ID_OUT.
  - Outputs ManufId, then DevId, alternating on each read advance.
- Reset command (0xFF): accepted in any state. Aborts the current operation, clears fail, BUSY for tRST cycles, then IDLE.
- BUSY: all commands except 0x70 and 0xFF are ignored. Address and data cycles are ignored. RB=0 for exactly the busy count cycles, starting the cycle after the confirm strobe.
- Column wrap: col is log2(PageBytes) bits and wraps PageBytes-1 -> 0. The address byte is truncated.
- Row range: row byte ≥ Pages on a program or erase sets fail=1, skips the array update and still goes busy. On a read it wraps modulo Pages.
- Command sequence errors:
  - An unknown command returns to IDLE.
  - A wrong confirm byte returns to IDLE with no array change.
  - Data cycles outside DATA_IN are ignored.
  - Read advances outside an output state are ignored.
- cEn=1 ignores all strobes; the state is held.

Decomposition:
- nand_target_pkg holds:
  - the command constants: CMD_READ=00, READ_CONF=30, PROG=80, PROG_CONF=10, ERASE=60, ERASE_CONF=D0, STATUS=70, ID=90, RESET=FF;
  - the state_t enum;
  - the status bit positions.
- Sub-module nand_strobe_detect: registers wEn and rEn, and outputs single-cycle wr_stb and rd_adv qualified by cEn.

Test Plan:
- Post-Reset, 0x70, one read -> DIO=0xC0, RB=1.
- 0x90, addr 0x00, 3 reads -> 0xEC, 0xDA, 0xEC.
- Program 0x80, col 0x02, row 0x05, data A5 3C, 0x10 -> RB low for 20 cycles. Then read 00/02/05/30 -> RB low 8 cycles, reads A5 3C FF.
- Program byte 0x0F over col 2 of row 5, read back -> 0x05 (AND). Erase 60/05/D0 -> pages 4–7 read 0xFF.
- Program at col 0x0F with 2 bytes 11 22 -> page bytes 15=0x11, 0=0x22. Row 0x20 program -> status bit0=1, array unchanged.
- 0x70 during tBERS busy -> DIO=0x80. 0xFF mid-erase -> RB low 4 cycles, erase not applied. Async Reset mid-program -> RB=1 immediately, DIO high-Z.
